// File: rtl/axis_pkt_pkg.sv
// axis_pkt_pkg: shared beat layout, default sizes and entry-width helper for the AXI-Stream packet FIFO.
// Ports: none (package).
package axis_pkt_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int USER_W_DEF = 2;
    localparam int DEPTH_DEF  = 16;

    // One buffered beat at the default widths; the FIFO packs fields in this same order.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]   tdata;
        logic [DATA_W_DEF/8-1:0] tstrb;
        logic [DATA_W_DEF/8-1:0] tkeep;
        logic [USER_W_DEF-1:0]   tuser;
        logic                    tlast;
    } beat_t;

    // Width of one stored beat: tdata + tstrb + tkeep + tuser + tlast.
    function automatic int beat_width(input int dw, input int uw);
        return dw + 2 * (dw / 8) + uw + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// axis_pkt_fifo_mem: simple dual-port array, synchronous write, asynchronous read.
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data (combinational from rd_addr)
module axis_pkt_fifo_mem
    import axis_pkt_pkg::*;
#(
    parameter int WIDTH = beat_width(DATA_W_DEF, USER_W_DEF),
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI-Stream packet FIFO with cut-through fallback for oversize packets.
// Ports:
//   axi_clk, axi_reset_n        clock, synchronous active-low reset
//   s_tdata..s_tlast, s_tvalid  slave stream in; s_tready out
//   m_tdata..m_tlast, m_tvalid  master stream out; m_tready in
//   level                       entries occupied, 0..DEPTH
//   pkt_cnt                     complete packets (tlast beats) held
//   pkt_total, level_max        only with AXIS_PKT_FIFO_STAT_EN: tlast-write count, level high-water mark
module axis_pkt_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int USER_WIDTH = USER_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [USER_WIDTH-1:0]   s_tuser,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic [USER_WIDTH-1:0]   m_tuser,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [AW:0]             level,
    output logic [AW:0]             pkt_cnt
`ifdef AXIS_PKT_FIFO_STAT_EN
    ,
    output logic [31:0]             pkt_total,
    output logic [AW:0]             level_max
`endif
);

    localparam int         BW   = beat_width(DATA_WIDTH, USER_WIDTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          oversize;
    logic          wr_en;
    logic          rd_en;
    logic [AW:0]   level_nxt;
    logic [AW:0]   pkt_nxt;
    logic [BW-1:0] wr_data;
    logic [BW-1:0] rd_data;

    assign s_tready  = level != FULL;
    assign m_tvalid  = (level != '0) && (pkt_cnt != '0 || oversize);
    assign wr_en     = s_tvalid && s_tready;
    assign rd_en     = m_tvalid && m_tready;
    assign level_nxt = level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    assign pkt_nxt   = pkt_cnt + (AW+1)'(wr_en && s_tlast) - (AW+1)'(rd_en && m_tlast);
    assign wr_data   = {s_tdata, s_tstrb, s_tkeep, s_tuser, s_tlast};
    assign {m_tdata, m_tstrb, m_tkeep, m_tuser, m_tlast} = rd_data;

    axis_pkt_fifo_mem #(
        .WIDTH(BW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk    (axi_clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pkt_cnt  <= '0;
            oversize <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level   <= level_nxt;
            pkt_cnt <= pkt_nxt;
            // A full FIFO with no complete packet can never release one; stream it out
            // until its tlast leaves. Set and clear cannot coincide: a tlast read needs pkt_cnt != 0.
            if (rd_en && m_tlast) oversize <= 1'b0;
            else if (level == FULL && pkt_cnt == '0) oversize <= 1'b1;
        end
    end

`ifdef AXIS_PKT_FIFO_STAT_EN
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            pkt_total <= '0;
            level_max <= '0;
        end else begin
            if (wr_en && s_tlast) pkt_total <= pkt_total + 1'b1;
            // Track against the next level so the peak shows up in the same cycle as level.
            if (level_nxt > level_max) level_max <= level_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: directed self-checking bench for axis_pkt_fifo.
module tb_axis_pkt_fifo;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic [3:0]  s_tkeep;
    logic [1:0]  s_tuser;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [3:0]  m_tkeep;
    logic [1:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  level;
    logic [4:0]  pkt_cnt;
`ifdef AXIS_PKT_FIFO_STAT_EN
    logic [31:0] pkt_total;
    logic [4:0]  level_max;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 axi_clk = ~axi_clk;

    axis_pkt_fifo dut (
        .axi_clk    (axi_clk),
        .axi_reset_n(axi_reset_n),
        .s_tdata    (s_tdata),
        .s_tstrb    (s_tstrb),
        .s_tkeep    (s_tkeep),
        .s_tuser    (s_tuser),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tstrb    (m_tstrb),
        .m_tkeep    (m_tkeep),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .level      (level),
        .pkt_cnt    (pkt_cnt)
`ifdef AXIS_PKT_FIFO_STAT_EN
        ,
        .pkt_total  (pkt_total),
        .level_max  (level_max)
`endif
    );

    task automatic tick;
        @(posedge axi_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
    endtask

    task automatic test_reset;
        axi_reset_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        s_tstrb = 4'hF; s_tkeep = 4'hF; s_tuser = 2'd0;
        m_tready = 1'b0;
        repeat (3) tick;
        total_cnt++; if (s_tready !== 1'b1) $display("FAIL reset_s_tready got %b want 1", s_tready); else pass_cnt++;
        total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd0) $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); else pass_cnt++;
        axi_reset_n = 1'b1;
        tick;
    endtask

    task automatic test_single_packet;
        logic [9:0] side;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h11 * (i + 1), i == 3);
            s_tstrb = 4'(i + 1); s_tkeep = ~4'(i + 1); s_tuser = 2'(i);
            tick;
            if (i < 3) begin
                total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL single_early_valid beat %0d got %b want 0", i, m_tvalid); else pass_cnt++;
            end
        end
        drive(1'b0, 32'h0, 1'b0);
        total_cnt++; if (m_tvalid !== 1'b1) $display("FAIL single_valid_after_tlast got %b want 1", m_tvalid); else pass_cnt++;
        for (int j = 0; j < 4; j++) begin
            side = {2'(j), ~4'(j + 1), 4'(j + 1)};
            total_cnt++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, j == 3, 32'h11 * (j + 1)})
                $display("FAIL single_beat %0d got v=%b l=%b d=%h want v=1 l=%b d=%h", j, m_tvalid, m_tlast, m_tdata, j == 3, 32'h11 * (j + 1));
            else pass_cnt++;
            total_cnt++;
            if ({m_tuser, m_tkeep, m_tstrb} !== side)
                $display("FAIL single_side %0d got %h want %h", j, {m_tuser, m_tkeep, m_tstrb}, side);
            else pass_cnt++;
            tick;
        end
        total_cnt++; if (pkt_cnt !== 5'd0) $display("FAIL single_pkt_cnt got %0d want 0", pkt_cnt); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL single_level got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL single_valid_end got %b want 0", m_tvalid); else pass_cnt++;
        s_tstrb = 4'hF; s_tkeep = 4'hF; s_tuser = 2'd0;
    endtask

    task automatic test_full_backpressure;
        int ri;
        logic wfire;
        logic [31:0] exp_d;
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), (i % 4) == 3);
            tick;
        end
        drive(1'b1, 32'hAA, 1'b1);
        repeat (2) tick;
        total_cnt++; if (level !== 5'd16) $display("FAIL full_level got %0d want 16", level); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd4) $display("FAIL full_pkt_cnt got %0d want 4", pkt_cnt); else pass_cnt++;
        total_cnt++; if (s_tready !== 1'b0) $display("FAIL full_s_tready got %b want 0", s_tready); else pass_cnt++;
        m_tready = 1'b1;
        ri = 0;
        for (int c = 0; c < 100 && ri < 17; c++) begin
            if (m_tvalid) begin
                exp_d = (ri < 16) ? 32'(ri) : 32'hAA;
                total_cnt++;
                if (m_tdata !== exp_d) $display("FAIL full_drain beat %0d got %h want %h", ri, m_tdata, exp_d);
                else pass_cnt++;
                ri++;
            end
            wfire = s_tvalid && s_tready;
            tick;
            if (wfire) s_tvalid = 1'b0;
        end
        total_cnt++; if (ri != 17) $display("FAIL full_drain_count got %0d want 17", ri); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL full_level_end got %0d want 0", level); else pass_cnt++;
    endtask

    task automatic test_simultaneous;
        m_tready = 1'b0;
        drive(1'b1, 32'h50, 1'b1);
        tick;
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 32'h50 + 32'(i), i == 7);
            tick;
        end
        drive(1'b0, 32'h0, 1'b0);
        total_cnt++; if (level !== 5'd8) $display("FAIL simul_pre_level got %0d want 8", level); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd2) $display("FAIL simul_pre_pkt_cnt got %0d want 2", pkt_cnt); else pass_cnt++;
        total_cnt++;
        if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 32'h50})
            $display("FAIL simul_head got v=%b l=%b d=%h want v=1 l=1 d=00000050", m_tvalid, m_tlast, m_tdata);
        else pass_cnt++;
        drive(1'b1, 32'h58, 1'b1);
        m_tready = 1'b1;
        tick;
        drive(1'b0, 32'h0, 1'b0);
        m_tready = 1'b0;
        total_cnt++; if (level !== 5'd8) $display("FAIL simul_level got %0d want 8", level); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd2) $display("FAIL simul_pkt_cnt got %0d want 2", pkt_cnt); else pass_cnt++;
        total_cnt++; if (m_tdata !== 32'h51) $display("FAIL simul_next_head got %h want 00000051", m_tdata); else pass_cnt++;
        m_tready = 1'b1;
        repeat (10) tick;
        total_cnt++; if (level !== 5'd0) $display("FAIL simul_drain_level got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (pkt_cnt !== 5'd0) $display("FAIL simul_drain_pkt_cnt got %0d want 0", pkt_cnt); else pass_cnt++;
    endtask

    task automatic test_oversize;
        int wi;
        int ri;
        logic wfire;
        logic saw_full;
        logic saw_ct;
        m_tready = 1'b1;
        wi = 0; ri = 0; saw_full = 1'b0; saw_ct = 1'b0;
        drive(1'b1, 32'h100, 1'b0);
        for (int c = 0; c < 200 && ri < 20; c++) begin
            if (level == 5'd16) saw_full = 1'b1;
            if (m_tvalid && pkt_cnt == 5'd0) saw_ct = 1'b1;
            if (m_tvalid) begin
                total_cnt++;
                if ({m_tlast, m_tdata} !== {ri == 19, 32'h100 + 32'(ri)})
                    $display("FAIL oversize_beat %0d got l=%b d=%h want l=%b d=%h", ri, m_tlast, m_tdata, ri == 19, 32'h100 + 32'(ri));
                else pass_cnt++;
                ri++;
            end
            wfire = s_tvalid && s_tready;
            tick;
            if (wfire) wi++;
            drive(wi < 20, 32'h100 + 32'(wi), wi == 19);
        end
        drive(1'b0, 32'h0, 1'b0);
        total_cnt++; if (ri != 20) $display("FAIL oversize_count got %0d want 20", ri); else pass_cnt++;
        total_cnt++; if (saw_full !== 1'b1) $display("FAIL oversize_reached_full got %b want 1", saw_full); else pass_cnt++;
        total_cnt++; if (saw_ct !== 1'b1) $display("FAIL oversize_cut_through got %b want 1", saw_ct); else pass_cnt++;
        tick;
        total_cnt++; if (level !== 5'd0) $display("FAIL oversize_level_end got %0d want 0", level); else pass_cnt++;
        // One beat without tlast must now be held back: cut-through has to be off again.
        drive(1'b1, 32'h200, 1'b0);
        tick;
        drive(1'b0, 32'h0, 1'b0);
        tick;
        total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL oversize_cleared got m_tvalid=%b want 0", m_tvalid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet;
        m_tready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0);
            tick;
        end
        drive(1'b0, 32'h0, 1'b0);
        total_cnt++; if (level !== 5'd5) $display("FAIL midrst_pre_level got %0d want 5", level); else pass_cnt++;
        axi_reset_n = 1'b0;
        tick;
        axi_reset_n = 1'b1;
        total_cnt++; if (level !== 5'd0) $display("FAIL midrst_level got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL midrst_m_tvalid got %b want 0", m_tvalid); else pass_cnt++;
        drive(1'b1, 32'hCAFE0001, 1'b0);
        tick;
        drive(1'b1, 32'hCAFE0002, 1'b1);
        tick;
        drive(1'b0, 32'h0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            total_cnt++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, j == 1, 32'hCAFE0001 + 32'(j)})
                $display("FAIL midrst_beat %0d got v=%b l=%b d=%h want v=1 l=%b d=%h", j, m_tvalid, m_tlast, m_tdata, j == 1, 32'hCAFE0001 + 32'(j));
            else pass_cnt++;
            tick;
        end
        total_cnt++; if (level !== 5'd0) $display("FAIL midrst_level_end got %0d want 0", level); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_single_packet;
        test_full_backpressure;
        test_simultaneous;
        test_oversize;
        test_reset_mid_packet;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Store-and-forward AXI-Stream packet FIFO directly downstream of the AXI-Lite-to-AXI-Stream bridge.
- Consumes the bridge's master stream and re-emits a packet only once its tlast beat is buffered, so downstream user logic never sees a bubble mid-packet.
- Reports fill level and number of complete packets held.
- A packet longer than the FIFO depth is released in cut-through mode to avoid deadlock.

Parameters:
- DATA_WIDTH, 32, tdata width; tstrb/tkeep width is DATA_WIDTH/8.
- USER_WIDTH, 2, tuser width.
- DEPTH, 16, entries; power of two, at least 4.
- AW, $clog2(DEPTH), pointer width.

Ports:
- axi_clk  in  1  single clock.
- axi_reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of axi_clk.
- s_tdata  in  DATA_WIDTH  slave data from the bridge.
- s_tstrb  in  DATA_WIDTH/8  byte strobe.
- s_tkeep  in  DATA_WIDTH/8  byte keep.
- s_tuser  in  USER_WIDTH  sideband.
- s_tlast  in  1  last beat of packet.
- s_tvalid  in  1  slave valid.
- s_tready  out  1  slave ready.
- m_tdata, m_tstrb, m_tkeep, m_tuser, m_tlast  out  same widths as the s_ signals  master payload.
- m_tvalid  out  1  master valid.
- m_tready  in  1  master ready.
- level  out  AW+1  entries occupied, 0..DEPTH.
- pkt_cnt  out  AW+1  complete packets (tlast beats) held.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH + 2*DATA_WIDTH/8 + USER_WIDTH + 1) array; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH; level is a separate counter.
- Write: s_tready = (level != DEPTH); registered-state only, no combinational path from m_tready.
  - A write fires when s_tvalid && s_tready; the entry is stored at wr_ptr and wr_ptr increments.
- Read: the m_ payload is driven combinationally from mem[rd_ptr].
  - m_tvalid = (level != 0) && (pkt_cnt != 0 || oversize).
  - A read fires when m_tvalid && m_tready; rd_ptr increments.
- level update: +1 on write only, -1 on read only, unchanged when both fire in the same cycle.
- pkt_cnt update: +1 when the write beat has tlast, -1 when the read beat has tlast; unchanged when both occur in the same cycle.
- Latency: a tlast written at edge N gives m_tvalid high in the cycle after edge N. A 1-beat packet therefore appears 1 cycle after acceptance.
- Full with a read in the same cycle: s_tready stays 0 that cycle; the freed slot becomes available in the next cycle.
- Oversize mode:
  - Set at an edge when level == DEPTH and pkt_cnt == 0.
  - While set, beats are forwarded as available (cut-through).
  - Cleared at the edge where a read beat with tlast fires; that tlast belongs to the oversize packet.
- AXI rules:
  - Once m_tvalid is asserted it stays high with stable payload until m_tready. This holds structurally because pkt_cnt and oversize cannot drop without a read.
  - Write and read may occur in the same cycle at any level below DEPTH.
- Reset (axi_reset_n low at an edge): wr_ptr, rd_ptr, level, pkt_cnt and oversize go to 0.
  - Consequently s_tready = 1 (at DEPTH>0), m_tvalid = 0, level = 0, pkt_cnt = 0.
  - Memory contents are not reset; m_ payload is don't-care while m_tvalid = 0.
  - A reset mid-packet discards all buffered beats, including partial packets.
- Whatever beats follow reset are treated as the start of a new packet.

Optional Feature:
- Macro AXIS_PKT_FIFO_STAT_EN.
- Defined: adds output ports pkt_total (32 bits) and level_max (AW+1 bits).
  - pkt_total counts every tlast write and wraps at 2^32.
  - level_max holds the high-water mark of level.
  - Both are cleared by reset.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package axis_pkt_pkg:
  - beat struct typedef (tdata, tstrb, tkeep, tuser, tlast), parameterised widths defaulted to 32/2.
  - Localparam for the default DEPTH.
- One sub-module: axis_pkt_fifo_mem, a simple dual-port array with synchronous write and asynchronous read.
- Pointer, counter and oversize logic stays in the top.

Test Plan:
- Reset: hold axi_reset_n low for 3 cycles → s_tready = 1, m_tvalid = 0, level = 0, pkt_cnt = 0.
- Single packet: write 4 beats 0x11..0x44 with tlast on 0x44 and m_tready = 1 → m_tvalid stays 0 until the cycle after the 0x44 write. Then 4 back-to-back beats appear in order, tlast on beat 4, and pkt_cnt returns to 0.
- Full backpressure: m_tready = 0, write four 4-beat packets (16 beats) → level = 16, pkt_cnt = 4, s_tready = 0. A 17th beat is held with no loss.
- Simultaneous: level = 8, pkt_cnt = 2; in one cycle write a tlast beat and read a tlast beat → level = 8, pkt_cnt = 2.
- Oversize: m_tready = 1, write a 20-beat packet → at level 16 with pkt_cnt = 0, oversize sets and output streams. All 20 beats exit in order, and oversize clears on the tlast read.
- Reset mid-packet: accept 5 beats without tlast, pulse reset → level = 0, m_tvalid = 0. A subsequent 2-beat packet exits intact.
